// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage_if
//  Purpose  : Bundles the ID/EX pipeline register signals. This covers the
//             decoder-side fields, the pipeline controls (stall, flush), the
//             registered EX-side fields and the status outputs.
//  Modports : master - decode stage / environment (drives id_*, controls)
//             slave  - id_ex_stage (drives ex_*, stall_out, halted, bubble_cnt)
//  Revision : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9
);
  // decode side
  logic              id_valid;
  logic              stall_in;
  logic              flush;
  logic              alu_src;
  logic [1:0]        wb_data_src;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        alu_op;
  logic [1:0]        ctrl_transfer;
  logic              halt;
  logic [PC_W-1:0]   id_pc;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [2:0]        id_funct3;
  logic [6:0]        id_funct7;
  // execute side
  logic              ex_valid;
  logic              ex_alu_src;
  logic [1:0]        ex_wb_data_src;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [1:0]        ex_alu_op;
  logic [1:0]        ex_ctrl_transfer;
  logic              ex_halt;
  logic [PC_W-1:0]   ex_pc;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [2:0]        ex_funct3;
  logic [6:0]        ex_funct7;
  // status
  logic              stall_out;
  logic              halted;
  logic [15:0]       bubble_cnt;

  modport master (
    output id_valid, stall_in, flush, alu_src, wb_data_src, reg_write,
           mem_read, mem_write, alu_op, ctrl_transfer, halt, id_pc, id_rd1,
           id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
    input  ex_valid, ex_alu_src, ex_wb_data_src, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_alu_op, ex_ctrl_transfer, ex_halt, ex_pc, ex_rd1,
           ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
           stall_out, halted, bubble_cnt
  );

  modport slave (
    input  id_valid, stall_in, flush, alu_src, wb_data_src, reg_write,
           mem_read, mem_write, alu_op, ctrl_transfer, halt, id_pc, id_rd1,
           id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
    output ex_valid, ex_alu_src, ex_wb_data_src, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_alu_op, ex_ctrl_transfer, ex_halt, ex_pc, ex_rd1,
           ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
           stall_out, halted, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register with flush, external stall, sticky
//             halt and optional load-use hazard detection / bubble insertion.
//  Ports    : clk   - single rising-edge clock
//             reset - synchronous active-high reset
//             bus   - id_ex_stage_if.slave (decode inputs, ex_* registered
//                     outputs, stall_out, halted, bubble_cnt)
//  Config   : define ID_EX_LOAD_USE_EN to enable load-use detection and the
//             bubble counter; otherwise load_use and bubble_cnt are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic       alu_src;
    logic [1:0] wb_data_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic [1:0] ctrl_transfer;
    logic       halt;
  } ctrl_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
  } data_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic        valid_q,      valid_d;
  ctrl_t       ctrl_q,       ctrl_d,  ctrl_in;
  data_t       data_q,       data_d,  data_in;
  logic        halted_q,     halted_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        load_use;

  assign ctrl_in = {bus.alu_src, bus.wb_data_src, bus.reg_write, bus.mem_read,
                    bus.mem_write, bus.alu_op, bus.ctrl_transfer, bus.halt};
  assign data_in = {bus.id_pc, bus.id_rd1, bus.id_rd2, bus.id_imm, bus.id_rs1,
                    bus.id_rs2, bus.id_rd, bus.id_funct3, bus.id_funct7};

`ifdef ID_EX_LOAD_USE_EN
  // x0 is never a real producer, so a load targeting it cannot create a hazard
  assign load_use = valid_q & ctrl_q.mem_read & (data_q.rd != 5'd0) &
                    bus.id_valid &
                    ((data_q.rd == bus.id_rs1) | (data_q.rd == bus.id_rs2));
`else
  assign load_use = 1'b0;
`endif

  assign bus.stall_out = load_use | bus.stall_in | halted_q;

  // Next-state: flush > stall_in > halted > load_use > load
  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    bubble_cnt_d = bubble_cnt_q;
    // a halt instruction reaching EX latches the sticky flag on the next edge
    halted_d     = halted_q | (valid_q & ctrl_q.halt);

    if (bus.flush) begin
      // data fields are left as they were; with valid and controls clear
      // the EX stage ignores them
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (bus.stall_in) begin
      // hold everything
    end else if (halted_q || load_use) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else begin
      valid_d = bus.id_valid;
      ctrl_d  = bus.id_valid ? ctrl_in : '0;
      data_d  = data_in;
    end

`ifdef ID_EX_LOAD_USE_EN
    // only a bubble actually inserted by the hazard branch above is counted
    if (load_use && !bus.flush && !bus.stall_in && !halted_q &&
        (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
`else
    bubble_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      data_q       <= '0;
      halted_q     <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      halted_q     <= halted_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_valid         = valid_q;
  assign bus.ex_alu_src       = ctrl_q.alu_src;
  assign bus.ex_wb_data_src   = ctrl_q.wb_data_src;
  assign bus.ex_reg_write     = ctrl_q.reg_write;
  assign bus.ex_mem_read      = ctrl_q.mem_read;
  assign bus.ex_mem_write     = ctrl_q.mem_write;
  assign bus.ex_alu_op        = ctrl_q.alu_op;
  assign bus.ex_ctrl_transfer = ctrl_q.ctrl_transfer;
  assign bus.ex_halt          = ctrl_q.halt;
  assign bus.ex_pc            = data_q.pc;
  assign bus.ex_rd1           = data_q.rd1;
  assign bus.ex_rd2           = data_q.rd2;
  assign bus.ex_imm           = data_q.imm;
  assign bus.ex_rs1           = data_q.rs1;
  assign bus.ex_rs2           = data_q.rs2;
  assign bus.ex_rd            = data_q.rd;
  assign bus.ex_funct3        = data_q.funct3;
  assign bus.ex_funct7        = data_q.funct7;
  assign bus.halted           = halted_q;
  assign bus.bubble_cnt       = bubble_cnt_q;

endmodule
`default_nettype wire
